// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - writeback arbiter bus: ALU request, load response, register file write port
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LQ_DEPTH   = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [4:0]            alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [4:0]            ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;

  logic                  rd_we;
  logic [4:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [CNT_W-1:0]      lq_count;
  logic [31:0]           pending_mask;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready,
    input  rd_we, rd_addr, rd_data,
    input  lq_count, pending_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready,
    output rd_we, rd_addr, rd_data,
    output lq_count, pending_mask
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges in-order ALU results and queued load responses into one register file write port
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(LQ_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT - 1);

  typedef enum logic [0:0] {
    ST_NORMAL,
    ST_FORCE
  } state_t;

  state_t                state_q, state_d;

  logic [4:0]            q_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [STV_W-1:0]      starve_q, starve_d;

  logic                  rd_we_q;
  logic [4:0]            rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  q_empty, q_full;
  logic                  push, pop;
  logic                  alu_fire, alu_use;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [31:0]           pend;

  assign q_empty  = (count_q == '0);
  assign q_full   = (count_q == FULL_CNT);

  // x0 loads are acknowledged but never occupy a queue entry.
  assign push     = bus.ld_valid && !q_full && (bus.ld_rd != 5'd0);
  assign alu_fire = bus.alu_valid && (state_q == ST_NORMAL);
  assign alu_use  = alu_fire && (bus.alu_rd != 5'd0);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = rd_addr_q;
    wr_data  = rd_data_q;
    case (state_q)
      ST_NORMAL: begin
        if (alu_use) begin
          wr_en   = 1'b1;
          wr_addr = bus.alu_rd;
          wr_data = bus.alu_data;
        end else if (!q_empty) begin
          pop     = 1'b1;
          wr_en   = 1'b1;
          wr_addr = q_rd[rd_ptr_q];
          wr_data = q_data[rd_ptr_q];
        end
        // Count non-draining cycles; the last one tips us into a forced drain.
        if (q_empty || pop) begin
          starve_d = '0;
        end else if (starve_q == STARVE_MAX) begin
          starve_d = '0;
          state_d  = ST_FORCE;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      ST_FORCE: begin
        pop      = !q_empty;
        wr_en    = !q_empty;
        wr_addr  = q_rd[rd_ptr_q];
        wr_data  = q_data[rd_ptr_q];
        starve_d = '0;
        state_d  = ST_NORMAL;
      end
      default: begin
        state_d  = ST_NORMAL;
        starve_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_NORMAL;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      rd_we_q   <= wr_en;
      rd_addr_q <= wr_addr;
      rd_data_q <= wr_data;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr_q]   <= bus.ld_rd;
      q_data[wr_ptr_q] <= bus.ld_data;
    end
  end

  always_comb begin
    pend = '0;
    for (int k = 0; k < LQ_DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        pend[q_rd[rd_ptr_q + PTR_W'(k)]] = 1'b1;
      end
    end
  end

  assign bus.alu_ready    = (state_q == ST_NORMAL);
  assign bus.ld_ready     = !q_full;
  assign bus.rd_we        = rd_we_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.lq_count     = count_q;
  assign bus.pending_mask = pend;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized checks of writeback_arbiter against a queue-based reference model
module tb_writeback_arbiter;
  localparam int DW = 32;
  localparam int LQ_DEPTH = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.DATA_WIDTH(DW), .LQ_DEPTH(LQ_DEPTH)) bus ();

  writeback_arbiter #(
    .DATA_WIDTH  (DW),
    .LQ_DEPTH    (LQ_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  ent_t wlog[$];
  int   m_starve = 0;
  bit   m_force  = 1'b0;
  int   maxcnt   = 0;
  bit   a_acc, l_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9;  bus.alu_data = 32'h5555_AAAA;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd4;  bus.ld_data  = 32'h1357_9BDF;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_rd_we", bus.rd_we, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_lq_count", bus.lq_count, 0);
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_pending_mask", bus.pending_mask, 0);
    mq.delete();
    m_starve = 0;
    m_force  = 1'b0;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  // One clock of the reference model: inputs are already driven by the caller.
  task automatic cycle(output bit alu_acc, output bit ld_acc);
    bit          exp_ar, exp_lr, exp_we, use_alu, popped, was_busy;
    logic [4:0]  ea;
    logic [31:0] ed, em;
    ent_t        h;
    #1;
    exp_ar = !m_force;
    exp_lr = (mq.size() < LQ_DEPTH);
    em = '0;
    foreach (mq[i]) em[mq[i].rd] = 1'b1;
    chk("alu_ready", bus.alu_ready, exp_ar);
    chk("ld_ready", bus.ld_ready, exp_lr);
    chk("lq_count", bus.lq_count, mq.size());
    chk("pending_mask", bus.pending_mask, em);
    if (int'(bus.lq_count) > maxcnt) maxcnt = int'(bus.lq_count);

    alu_acc  = bus.alu_valid && exp_ar;
    ld_acc   = bus.ld_valid && exp_lr;
    use_alu  = alu_acc && (bus.alu_rd != 0);
    was_busy = (mq.size() > 0);
    exp_we = 1'b0; ea = '0; ed = '0; popped = 1'b0;
    if (!m_force && use_alu) begin
      exp_we = 1'b1; ea = bus.alu_rd; ed = bus.alu_data;
    end else if (was_busy) begin
      h = mq.pop_front();
      popped = 1'b1;
      exp_we = 1'b1; ea = h.rd; ed = h.data;
    end
    if (m_force) begin
      m_force = 1'b0;
      m_starve = 0;
    end else if (!was_busy || popped) begin
      m_starve = 0;
    end else begin
      m_starve++;
      if (m_starve == STARVE_LIMIT) begin
        m_force = 1'b1;
        m_starve = 0;
      end
    end
    if (ld_acc && bus.ld_rd != 0) mq.push_back('{rd: bus.ld_rd, data: bus.ld_data});

    @(posedge clk);
    #1;
    chk("rd_we", bus.rd_we, exp_we);
    if (exp_we) begin
      chk("rd_addr", bus.rd_addr, ea);
      chk("rd_data", bus.rd_data, ed);
    end
    if (bus.rd_we) wlog.push_back('{rd: bus.rd_addr, data: bus.rd_data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] wrap_rd[10];
    ent_t       exp_w[$];
    ent_t       got_w[$];
    int         force_at, lows, zero_writes;
    bit         alu_pend, ld_pend;

    idle_inputs();
    do_reset(2);

    // ALU stream
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    cycle(a_acc, l_acc);
    chk("alu_we", bus.rd_we, 1);
    chk("alu_addr", bus.rd_addr, 5);
    chk("alu_data", bus.rd_data, 32'h1234);
    bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
    cycle(a_acc, l_acc);
    chk("alu_x0_we", bus.rd_we, 0);

    // Idle drain
    bus.alu_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'hCAFE;
    cycle(a_acc, l_acc);
    chk("drain_mask", bus.pending_mask, 32'h80);
    chk("drain_count", bus.lq_count, 1);
    bus.ld_valid = 1'b0;
    cycle(a_acc, l_acc);
    chk("drain_we", bus.rd_we, 1);
    chk("drain_addr", bus.rd_addr, 7);
    chk("drain_data", bus.rd_data, 32'hCAFE);
    chk("drain_mask_clr", bus.pending_mask, 0);

    // Full queue with the ALU busy every cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1;
    for (int k = 0; k < 4; k++) begin
      bus.alu_data = 32'h100 + k;
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(10 + k); bus.ld_data = 32'hD000 + k;
      cycle(a_acc, l_acc);
    end
    bus.alu_data = 32'h104;
    bus.ld_rd = 5'd14; bus.ld_data = 32'hD004;
    #1;
    chk("full_count", bus.lq_count, 4);
    chk("full_ld_ready", bus.ld_ready, 0);
    bus.alu_valid = 1'b0;
    l_acc = 1'b0;
    for (int i = 0; i < 20 && !l_acc; i++) cycle(a_acc, l_acc);
    chk("full_5th_accepted", l_acc, 1);
    bus.ld_valid = 1'b0;
    for (int i = 0; i < 8; i++) cycle(a_acc, l_acc);
    chk("full_drained", bus.lq_count, 0);

    // Starvation: one queued load behind a continuous ALU stream to r3
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3000;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'hBEEF;
    cycle(a_acc, l_acc);
    bus.ld_valid = 1'b0;
    force_at = -1;
    lows = 0;
    for (int i = 1; i <= 12; i++) begin
      if (a_acc) bus.alu_data = 32'h3000 + i;
      #1;
      if (bus.alu_ready !== 1'b1) begin
        lows++;
        if (force_at < 0) force_at = i;
      end
      cycle(a_acc, l_acc);
      if (i == force_at) begin
        chk("force_we", bus.rd_we, 1);
        chk("force_addr", bus.rd_addr, 7);
        chk("force_data", bus.rd_data, 32'hBEEF);
      end
    end
    chk("starve_force_cycle", force_at, 9);
    chk("starve_force_len", lows, 1);

    // Wrap-around with x0 loads; ALU writes to r1 compete for the port
    wrap_rd = '{5'd3, 5'd0, 5'd9, 5'd17, 5'd0, 5'd31, 5'd2, 5'd0, 5'd12, 5'd5};
    exp_w.delete();
    wlog.delete();
    maxcnt = 0;
    bus.alu_rd = 5'd1;
    for (int k = 0; k < 10; k++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = wrap_rd[k]; bus.ld_data = 32'hA000 + k;
      if (wrap_rd[k] != 0) exp_w.push_back('{rd: wrap_rd[k], data: 32'hA000 + k});
      l_acc = 1'b0;
      for (int t = 0; t < 12 && !l_acc; t++) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0) || !a_acc;
        if (a_acc) bus.alu_data = 32'h1_0000 + $urandom_range(0, 255);
        cycle(a_acc, l_acc);
      end
      chk("wrap_ld_accepted", l_acc, 1);
    end
    bus.ld_valid = 1'b0;
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 8; i++) cycle(a_acc, l_acc);
    got_w.delete();
    zero_writes = 0;
    foreach (wlog[i]) begin
      if (wlog[i].rd == 0) zero_writes++;
      if (wlog[i].rd != 1) got_w.push_back(wlog[i]);
    end
    chk("wrap_no_x0_write", zero_writes, 0);
    chk("wrap_max_count", maxcnt <= LQ_DEPTH, 1);
    chk("wrap_write_count", got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      chk("wrap_order", got_w[i], exp_w[i]);
    end

    // Randomized traffic with a reset in the middle
    alu_pend = 1'b0;
    ld_pend  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset(1);
        alu_pend = 1'b0;
        ld_pend  = 1'b0;
      end
      if (!alu_pend) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_data  = $urandom;
      end
      if (!ld_pend) begin
        bus.ld_valid = ($urandom_range(0, 2) == 0);
        bus.ld_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.ld_data  = $urandom;
      end
      cycle(a_acc, l_acc);
      alu_pend = bus.alu_valid && !a_acc;
      ld_pend  = bus.ld_valid && !l_acc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Single-port writeback arbiter for the rv32i core. It merges ALU results (one per cycle, in-order) and out-of-order memory load responses into the one write port of the 32-entry register file, driving its rd_we/rd_addr/rd_data inputs. Load results are held in a small FIFO and drain through free write slots. A starvation counter forces a drain slot so loads are never delayed indefinitely.

## Interface
- DATA_WIDTH, 32: register/data width.
- LQ_DEPTH, 4: load queue entries; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive non-draining cycles with a non-empty queue before a forced drain; at least 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU writeback accepted this cycle when high together with alu_valid.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load response valid.
- ld_ready  out  1  load queue can accept.
- ld_rd  in  5  load destination register.
- ld_data  in  DATA_WIDTH  load data.
- rd_we  out  1  register file write enable (registered).
- rd_addr  out  5  register file write address (registered).
- rd_data  out  DATA_WIDTH  register file write data (registered).
- lq_count  out  clog2(LQ_DEPTH)+1  queue occupancy.
- pending_mask  out  32  bit r set while any queued entry targets register r.

## Operation
- Reset values:
  - rd_we=0, rd_addr=0, rd_data=0.
  - alu_ready=1, ld_ready=1.
  - lq_count=0, pending_mask=0.
  - Queue pointers 0, starve_cnt=0, state NORMAL.
- Load enqueue: ld_valid && ld_ready.
  - ld_rd != 0: push {ld_rd, ld_data}.
  - ld_rd == 0: accept and discard; no push.
- ld_ready = (lq_count != LQ_DEPTH), combinational from the count.
- ALU acceptance: alu_valid && alu_ready.
  - An ALU transfer "uses the slot" only if alu_rd != 0.
  - An x0 transfer is accepted and dropped.
- State NORMAL, alu_ready=1:
  - If the slot is used: write {alu_rd, alu_data}.
  - Otherwise, if the queue is non-empty: pop the head and write it (drain).
  - starve_cnt increments when the queue is non-empty and no pop occurs. It clears on any pop or when the queue is empty.
  - When starve_cnt reaches STARVE_LIMIT-1 and the current cycle also does not pop, go to FORCE.
- State FORCE, alu_ready=0:
  - Pop the head and write it. Clear starve_cnt and return to NORMAL.
  - The ALU must hold alu_valid, alu_rd and alu_data stable.
- At most one pop per cycle. Simultaneous push and pop leave lq_count unchanged. Push while full is impossible.
- Ordering between the ALU and a load to the same rd is the issue scoreboard's responsibility; it uses pending_mask for this.
- pending_mask is the OR of one-hot(rd) over valid entries, computed from registered queue state.
- Wrap-around: pointers are clog2(LQ_DEPTH) bits and wrap modulo LQ_DEPTH. Full/empty are derived from lq_count.

## Timing
- Write latency:
  - A transfer accepted at edge N produces rd_we=1 with its addr/data after edge N (in the cycle N..N+1).
  - The register file captures it at edge N+1.
- Load path:
  - A load pushed at edge N is poppable in the cycle after edge N.
  - Its earliest rd_we is in the cycle after edge N+1.
  - No bypass around the queue.
- rd_we=0 in any cycle after an edge with no ALU write and no pop.
- FORCE lasts exactly one cycle. A new FORCE needs STARVE_LIMIT further non-draining cycles.
- Reset mid-operation: queue contents are lost, pending_mask=0, and every output returns to its reset value at the next edge where rst_n=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all inputs active -> rd_we=0, lq_count=0, alu_ready=1, ld_ready=1, pending_mask=0.
- ALU stream:
  - alu_rd=5, data 0x1234 at edge N -> rd_we=1, rd_addr=5, rd_data=0x1234 after N.
  - alu_rd=0 -> rd_we=0.
- Idle drain:
  - Push a load {rd=7, 0xCAFE} with the ALU idle -> pending_mask=0x80, lq_count=1.
  - Next cycle it pops; rd_addr=7, rd_data=0xCAFE in the following cycle, then mask 0.
- Full queue: push 4 loads with the ALU busy each cycle -> ld_ready=0 at lq_count=4. A 5th ld_valid is held, not lost.
- Starvation:
  - Queue 1 entry and keep alu_valid=1 with rd=3 every cycle.
  - After 8 non-draining cycles, alu_ready=0 for exactly 1 cycle and the load is written.
  - The held ALU write to r3 follows next.
- Wrap and x0 loads:
  - Push 10 loads through a 4-deep queue, including rd=0 entries -> written in FIFO order.
  - rd=0 loads are never written; lq_count never exceeds 4.
